// File: rtl/cb_pkg.sv
// Shared encodings for covariance-bank port B: direction codes, NEW landmark
// halves, mapper group codes and the write-sequencer FSM states.
package cb_pkg;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b10;
  localparam logic [1:0] DIR_NEW  = 2'b11;

  // l_k_0 value selecting which half of the banks a NEW write touches
  localparam logic DIR_NEW_0 = 1'b0;
  localparam logic DIR_NEW_1 = 1'b1;

  localparam logic [2:0] CBB_GRP_W  = 3'd3;
  localparam logic [2:0] CBb_IDLE   = 3'd0;
  localparam logic [2:0] CBb_C      = 3'd1;
  localparam logic [2:0] CBb_xyxita = 3'd2;
  localparam logic [2:0] CBb_lxly   = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } cb_wr_state_e;

endpackage

// File: rtl/cb_bank_we_dec.sv
// Combinational per-bank write mask from (direction, l_k_0).
module cb_bank_we_dec
  import cb_pkg::*;
#(
  parameter int L = 4
) (
  input  logic [1:0]   dir,
  input  logic         l_k_0,
  output logic [L-1:0] we_mask
);

  always_comb begin
    we_mask = '0;
    case (dir)
      DIR_POS, DIR_NEG: we_mask = '1;
      DIR_NEW: begin
        // l_k_0 = DIR_NEW_1 selects the lower half of the banks
        for (int i = 0; i < L; i++) begin
          we_mask[i] = (i < L / 2) ? (l_k_0 == DIR_NEW_1) : (l_k_0 == DIR_NEW_0);
        end
      end
      default: we_mask = '0;
    endcase
  end

endmodule

// File: rtl/cb_portb_wr_seq.sv
// Port-B write sequencer for the covariance banks; drives the CB port-B mapper.
// Optional address bound checking is enabled with `define CB_WR_BOUND_CHK_EN.
module cb_portb_wr_seq
  import cb_pkg::*;
#(
  parameter int L              = 4,
  parameter int CB_AW          = 10,
  parameter int SEQ_CNT_DW     = 5,
  parameter int CB_DINB_SEL_DW = 5
`ifdef CB_WR_BOUND_CHK_EN
  ,
  parameter int CB_DEPTH       = 2 ** CB_AW
`endif
) (
  input  logic                      clk,
  input  logic                      sys_rst,
  // cmd_valid/cmd_ready: a command transfers in the cycle both are high;
  // cmd_ready is high only in IDLE and never depends on cmd_valid.
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_dir,
  input  logic                      cmd_l_k_0,
  input  logic [CB_AW-1:0]          cmd_base,
  input  logic [SEQ_CNT_DW-1:0]     cmd_len,
  input  logic                      c_valid,
  output logic [CB_DINB_SEL_DW-1:0] CB_dinb_sel,
  output logic                      l_k_0,
  output logic [SEQ_CNT_DW-1:0]     seq_cnt_out,
  output logic [L-1:0]              CB_enb,
  output logic [L-1:0]              CB_web,
  output logic [L*CB_AW-1:0]        CB_addrb,
`ifdef CB_WR_BOUND_CHK_EN
  output logic                      addr_err,
`endif
  output logic                      done,
  output cb_wr_state_e              state_dbg
);

  localparam int EW = CB_AW + SEQ_CNT_DW + 1;

  cb_wr_state_e            state_q, state_d;
  logic [1:0]              dir_q, dir_d;
  logic                    lk_q, lk_d;
  logic [CB_AW-1:0]        base_q, base_d;
  logic [SEQ_CNT_DW-1:0]   len_q, len_d;
  logic [SEQ_CNT_DW-1:0]   beat_q, beat_d;
  logic [L-1:0]            wr_mask_q, wr_mask_d;
  logic [CB_AW-1:0]        addr_q, addr_d;
  logic [L-1:0]            dec_mask;
  logic                    beat;
  logic [SEQ_CNT_DW-1:0]   k;
  logic [EW-1:0]           addr_full;
`ifdef CB_WR_BOUND_CHK_EN
  logic                    err_q, err_d;
  logic                    out_of_range;
`endif

  cb_bank_we_dec #(.L(L)) u_we_dec (
    .dir     (dir_q),
    .l_k_0   (lk_q),
    .we_mask (dec_mask)
  );

  // Address computed unwrapped so a bound check can see overflow/underflow.
  always_comb begin
    k = beat_q - SEQ_CNT_DW'(1);
    if (dir_q == DIR_NEG) addr_full = EW'(base_q) - EW'(k);
    else                  addr_full = EW'(base_q) + EW'(k);
  end

`ifdef CB_WR_BOUND_CHK_EN
  assign out_of_range = ((dir_q == DIR_NEG) && (EW'(k) > EW'(base_q))) ||
                        (addr_full >= EW'(CB_DEPTH));
`endif

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    lk_d      = lk_q;
    base_d    = base_q;
    len_d     = len_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    wr_mask_d = '0;
    beat      = 1'b0;
`ifdef CB_WR_BOUND_CHK_EN
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          dir_d   = cmd_dir;
          lk_d    = cmd_l_k_0;
          base_d  = cmd_base;
          len_d   = cmd_len;
          beat_d  = SEQ_CNT_DW'(1);
          state_d = (cmd_len != '0) ? ST_RUN : ST_LAST;
`ifdef CB_WR_BOUND_CHK_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        if (c_valid) begin
          beat = 1'b1;
          if (beat_q == len_q) state_d = ST_LAST;
          else                 beat_d  = beat_q + SEQ_CNT_DW'(1);
        end
      end
      ST_LAST: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (beat) begin
      wr_mask_d = dec_mask;
      addr_d    = addr_full[CB_AW-1:0];
`ifdef CB_WR_BOUND_CHK_EN
      if (out_of_range) begin
        wr_mask_d = '0;
        err_d     = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_IDLE;
      lk_q      <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      wr_mask_q <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      lk_q      <= lk_d;
      base_q    <= base_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      wr_mask_q <= wr_mask_d;
      addr_q    <= addr_d;
    end
  end

`ifdef CB_WR_BOUND_CHK_EN
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) err_q <= 1'b0;
    else          err_q <= err_d;
  end
  assign addr_err = err_q;
`endif

  assign cmd_ready   = (state_q == ST_IDLE);
  assign done        = (state_q == ST_LAST);
  assign state_dbg   = state_q;
  assign l_k_0       = lk_q;
  assign CB_dinb_sel = (state_q == ST_RUN) ? CB_DINB_SEL_DW'({CBb_C, dir_q}) : '0;
  assign seq_cnt_out = (state_q == ST_RUN) ? beat_q : '0;
  assign CB_enb      = wr_mask_q;
  assign CB_web      = wr_mask_q;
  assign CB_addrb    = {L{addr_q}};

endmodule
